// File: rtl/fetch_sequencer.sv
// Fetch sequencer: walks the PC through instruction memory, waits on the ready
// handshake, applies branch/jump redirects and holds the fetched word under stall.
module fetch_sequencer #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                MAX_WAIT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_current,
  output logic              pc_write,
  output logic [ADDR_W-1:0] pc_next,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jump_target,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  output logic              timeout
);

  localparam int              CNT_W     = $clog2(MAX_WAIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic [1:0] {INIT, FETCH, HOLD} state_t;

  state_t            state, state_nxt;
  logic              pend_vld;
  logic              pend_br;
  logic [ADDR_W-1:0] pend_tgt;
  logic [CNT_W-1:0]  wait_cnt;
  logic              redirect;
  logic [ADDR_W-1:0] redir_tgt;

  function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] pc);
    return pc + ADDR_W'(4);
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + CNT_W'(1);
  endfunction

  // Branches (live or pending) beat jumps (live or pending); a live branch beats a pending one.
  assign redirect  = branch_taken | jump | pend_vld;
  assign redir_tgt = branch_taken         ? branch_target :
                     (pend_vld & pend_br) ? pend_tgt      :
                     jump                 ? jump_target   : pend_tgt;
  assign imem_addr = pc_current;

  always_comb begin
    state_nxt = state;
    pc_write  = 1'b0;
    pc_next   = pc_current;
    imem_req  = 1'b0;
    if (!reset) begin
      state_nxt = INIT;
      pc_write  = 1'b1;
      pc_next   = RESET_PC;
    end else begin
      case (state)
        INIT: state_nxt = FETCH;
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            if (redirect) begin
              pc_write = 1'b1;
              pc_next  = redir_tgt;
            end else if (!stall) begin
              pc_write = 1'b1;
              pc_next  = pc_inc(pc_current);
            end else begin
              state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            pc_write  = 1'b1;
            pc_next   = redir_tgt;
            state_nxt = FETCH;
          end else if (!stall) begin
            pc_write  = 1'b1;
            pc_next   = pc_inc(instr_pc);
            state_nxt = FETCH;
          end
        end
        default: state_nxt = INIT;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) state <= INIT;
    else        state <= state_nxt;
  end

  // Control: pending redirect, wait counter, timeout, valid.
  always_ff @(posedge clk) begin
    if (!reset || state == INIT) begin
      pend_vld    <= 1'b0;
      pend_br     <= 1'b0;
      pend_tgt    <= '0;
      wait_cnt    <= '0;
      timeout     <= 1'b0;
      instr_valid <= 1'b0;
    end else if (state == FETCH) begin
      if (imem_ready) begin
        wait_cnt    <= '0;
        pend_vld    <= 1'b0;
        instr_valid <= !redirect;
      end else begin
        wait_cnt <= sat_inc(wait_cnt);
        if (wait_cnt >= WAIT_LAST) timeout <= 1'b1;
        if (branch_taken) begin
          pend_vld <= 1'b1;
          pend_br  <= 1'b1;
          pend_tgt <= branch_target;
        end else if (jump && !(pend_vld && pend_br)) begin
          pend_vld <= 1'b1;
          pend_br  <= 1'b0;
          pend_tgt <= jump_target;
        end
        if (!stall) instr_valid <= 1'b0;
      end
    end else if (state == HOLD) begin
      if (redirect) instr_valid <= 1'b0;
    end
  end

  // Data: fetched word and its PC, captured on every non-redirected completion.
  always_ff @(posedge clk) begin
    if (!reset || state == INIT) begin
      instr    <= '0;
      instr_pc <= '0;
    end else if (state == FETCH && imem_ready && !redirect) begin
      instr    <= imem_data;
      instr_pc <= pc_current;
    end
  end

endmodule

// File: doc/fetch_sequencer.md
Name: fetch_sequencer

Overview:
- Sequences the program counter register and the instruction-memory fetch for the MIPS core.
- Issues fetch requests at the current PC and waits on a ready handshake.
- Drives the PC write-enable and next-PC value, and applies branch/jump redirects and pipeline stalls.
- Sits between the PC register, instruction memory and the IF/ID stage.

Parameters:
- ADDR_W, 32, PC / instruction address width.
- RESET_PC, 32'h0000_0000, PC value forced on reset.
- MAX_WAIT, 16, cycles of imem_ready low in FETCH before timeout asserts.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset, sampled on posedge clk).
- pc_current  in  ADDR_W  current PC register value.
- pc_write  out  1  PC register write enable.
- pc_next  out  ADDR_W  value loaded into the PC when pc_write=1.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  ADDR_W  fetch address; equals pc_current.
- imem_ready  in  1  fetch-complete strobe; imem_data valid this cycle.
- imem_data  in  32  fetched instruction word.
- stall  in  1  hazard-unit stall; IF/ID must hold.
- branch_taken  in  1  EX-stage branch resolved taken (1-cycle pulse).
- branch_target  in  ADDR_W  branch destination.
- jump  in  1  ID-stage jump (1-cycle pulse).
- jump_target  in  ADDR_W  jump destination.
- instr  out  32  instruction to IF/ID.
- instr_pc  out  ADDR_W  PC of instr.
- instr_valid  out  1  instr is valid and not squashed.
- timeout  out  1  sticky fetch-timeout flag.

Behaviour:
- States: INIT, FETCH, HOLD.
- Reset (reset=0 at posedge):
  - state=INIT; pc_write=1 with pc_next=RESET_PC; imem_req=0; instr_valid=0; instr=0; instr_pc=0; timeout=0.
  - Pending-redirect register and wait counter cleared.
- Reset mid-fetch: any outstanding request is abandoned and a late imem_ready is ignored in INIT.
- INIT:
  - Registered outputs are all cleared; pc_write is deasserted.
  - Lasts exactly one cycle, then goes to FETCH.
- FETCH:
  - imem_req=1, imem_addr=pc_current. The wait counter increments each cycle imem_ready=0.
  - On counter reaching MAX_WAIT: timeout goes to 1 and stays 1 until reset. The fetch keeps waiting.
  - On imem_ready=1, the next-PC priority is:
    1. branch_taken (this cycle or pending), target branch_target;
    2. jump (this cycle or pending), target jump_target;
    3. otherwise pc_current+4 (mod 2^ADDR_W, wraps 32'hFFFF_FFFC -> 0).
  - Redirect case (taken branch or jump): pc_write=1, pc_next=target. The fetched word is squashed (instr_valid=0), the pending redirect is cleared, and state stays FETCH.
  - No redirect, stall=0: pc_write=1, pc_next=pc_current+4. Next cycle instr=imem_data, instr_pc=pc_current, instr_valid=1. State stays FETCH.
  - No redirect, stall=1: pc_write=0. instr/instr_pc are captured with instr_valid=1; go HOLD.
  - Redirect pulses arriving while imem_ready=0 are latched as pending. A branch overwrites a pending jump; a jump does not overwrite a pending branch.
- HOLD:
  - imem_req=0, pc_write=0. instr, instr_pc and instr_valid are held stable.
  - Redirect (branch priority over jump): pc_write=1, pc_next=target, instr_valid=0 next cycle, go FETCH. Applies regardless of stall.
  - Otherwise stall=0: pc_write=1, pc_next=instr_pc+4, go FETCH.
  - Otherwise stall=1: remain in HOLD.
- FETCH with stall=1 and no completed fetch: the request continues and instr_valid holds its previous value.
- Latency:
  - Fetch complete to instr_valid: 1 cycle.
  - Redirect to the first request at the target: 1 cycle (pc_write in the redirect cycle, request the next cycle).
- pc_write is asserted at most once per fetch. pc_next is don't-care when pc_write=0 and is driven as pc_current.

Test Plan:
1. Reset low 2 cycles, release; imem_ready=1 every FETCH cycle with imem_data=0x20080001 onward → pc_next sequence 0, 4, 8, C. The first instr_valid appears 2 cycles after release with instr_pc=0. timeout stays 0.
2. imem_ready delayed 3 cycles per fetch → imem_req held high, pc_write pulses once per fetch, instr_pc increments by 4.
3. Stall=1 on the fetch at PC=0x8 for 4 cycles → state HOLD, instr/instr_pc=0x8 stable, pc_write=0. On stall release: pc_next=0xC.
4. branch_taken pulse with target 0x100 while the fetch at 0x10 is waiting; imem_ready 2 cycles later → pc_next=0x100, word from 0x10 squashed (instr_valid=0), next request at 0x100.
5. branch_taken (0x200) and jump (0x300) in the same cycle; also jump, then branch a cycle later during a wait → pc_next=0x200 in both cases.
6. imem_ready held low 16 cycles → timeout=1 and sticky after ready returns. Then reset=0 mid-wait → outputs cleared, timeout=0, pc_next=RESET_PC.
